// File: rtl/interlaken_rpt_sequencer.sv
// Purpose: repeater-side Interlaken latency-bench sequencer; answers driver START tokens with LBUS restarts and pass/fail reports.
// Latency: every state change and every output is registered; a sampled condition acts on the next clock edge.
// Backpressure: one outbound token is pending at most; its code holds while hs_tx_valid && !hs_tx_ready.
module interlaken_rpt_sequencer #(
  parameter int unsigned NUM_ROUNDS      = 2,
  parameter int unsigned ANNOUNCE_PERIOD = 1024,
  parameter logic [19:0] TIMEOUT_CYCLES  = 20'hFFFFF
) (
  input  logic       init_clk,
  input  logic       sys_reset,
  input  logic       rx_gt_locked,
  input  logic       rx_aligned,
  input  logic       tx_done,
  input  logic       tx_busy,
  input  logic       rx_done,
  input  logic       rx_busy,
  input  logic       rx_failed,
  input  logic       hs_rx_valid,
  input  logic [3:0] hs_rx_code,
  output logic       hs_tx_valid,
  output logic [3:0] hs_tx_code,
  input  logic       hs_tx_ready,
  output logic       lbus_tx_rx_restart_in,
  output logic [3:0] round_cnt,
  output logic [3:0] state,
  output logic       done,
  output logic       fail,
  output logic       timed_out
);

  typedef enum logic [3:0] {
    S_GT_LOCK_WAIT  = 4'd0,
    S_RX_ALIGN_WAIT = 4'd1,
    S_ANNOUNCE      = 4'd2,
    S_SEND_ACK      = 4'd3,
    S_RESTART_WAIT  = 4'd4,
    S_RESTART_PULSE = 4'd5,
    S_BUSY_WAIT     = 4'd6,
    S_RUN           = 4'd7,
    S_REPORT        = 4'd8,
    S_FINISHED      = 4'd9,
    S_ERROR         = 4'd10
  } state_e;

  localparam logic [3:0] TOK_READY = 4'h1;
  localparam logic [3:0] TOK_ACK   = 4'h2;
  localparam logic [3:0] TOK_START = 4'h3;
  localparam logic [3:0] TOK_PASS  = 4'h5;
  localparam logic [3:0] TOK_FAIL  = 4'h6;
  localparam logic [3:0] TOK_ABORT = 4'hF;

  localparam int          AW       = (ANNOUNCE_PERIOD > 1) ? $clog2(ANNOUNCE_PERIOD) : 1;
  localparam logic [AW-1:0] ANN_LAST = AW'(ANNOUNCE_PERIOD - 1);
  localparam logic [3:0]  LAST_RND = 4'(NUM_ROUNDS);

  state_e        state_q, state_d;
  logic          tx_vld_q, tx_vld_d;
  logic [3:0]    tx_code_q, tx_code_d;
  logic          restart_q, restart_d;
  logic [3:0]    round_q, round_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          to_q, to_d;
  logic [19:0]   wd_q, wd_d;
  logic [AW-1:0] ann_q, ann_d;
  logic          start_q, start_d;
  logic          txd_q, txd_d;
  logic          rxd_q, rxd_d;
  logic          rxf_q, rxf_d;
  logic          abort_pend_q, abort_pend_d;

  logic          q_tok;
  logic [3:0]    q_code;
  logic          err_go;

  // Decoded inputs and state classes shared by the next-state logic.
  logic rx_start, rx_abort, tx_acc, tx_free, link_st, wd_st, live_st;
  assign rx_start = hs_rx_valid && (hs_rx_code == TOK_START);
  assign rx_abort = hs_rx_valid && (hs_rx_code == TOK_ABORT);
  assign tx_acc   = tx_vld_q && hs_tx_ready;
  assign tx_free  = !tx_vld_q;
  assign link_st  = (state_q >= S_ANNOUNCE) && (state_q <= S_REPORT);
  assign wd_st    = (state_q >= S_RX_ALIGN_WAIT) && (state_q <= S_REPORT);
  assign live_st  = (state_q != S_FINISHED) && (state_q != S_ERROR);

  // State register and all registered outputs; reset drops any pending token silently.
  always_ff @(posedge init_clk) begin
    if (sys_reset) begin
      state_q      <= S_GT_LOCK_WAIT;
      tx_vld_q     <= 1'b0;
      tx_code_q    <= 4'h0;
      restart_q    <= 1'b0;
      round_q      <= 4'd0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      to_q         <= 1'b0;
      wd_q         <= '0;
      ann_q        <= '0;
      start_q      <= 1'b0;
      txd_q        <= 1'b0;
      rxd_q        <= 1'b0;
      rxf_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_vld_q     <= tx_vld_d;
      tx_code_q    <= tx_code_d;
      restart_q    <= restart_d;
      round_q      <= round_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      to_q         <= to_d;
      wd_q         <= wd_d;
      ann_q        <= ann_d;
      start_q      <= start_d;
      txd_q        <= txd_d;
      rxd_q        <= rxd_d;
      rxf_q        <= rxf_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Next state, token queueing and sticky flags; error causes override the normal flow.
  always_comb begin
    state_d      = state_q;
    tx_vld_d     = tx_vld_q && !hs_tx_ready;
    tx_code_d    = tx_code_q;
    restart_d    = 1'b0;
    round_d      = round_q;
    done_d       = done_q;
    fail_d       = fail_q;
    to_d         = to_q;
    start_d      = start_q;
    txd_d        = txd_q;
    rxd_d        = rxd_q;
    rxf_d        = rxf_q;
    abort_pend_d = abort_pend_q;
    q_tok        = 1'b0;
    q_code       = tx_code_q;
    err_go       = 1'b0;
    wd_d         = '0;
    ann_d        = '0;

    case (state_q)
      S_GT_LOCK_WAIT:  if (rx_gt_locked) state_d = S_RX_ALIGN_WAIT;
      S_RX_ALIGN_WAIT: if (rx_aligned) state_d = S_ANNOUNCE;
      S_ANNOUNCE: begin
        start_d = start_q || rx_start;
        if (start_q && tx_free) begin
          state_d = S_SEND_ACK;
        end else if (ann_q == '0 && tx_free) begin
          q_tok  = 1'b1;
          q_code = TOK_READY;
        end
      end
      S_SEND_ACK: begin
        if (tx_acc) begin
          state_d = S_RESTART_WAIT;
        end else if (tx_free) begin
          q_tok  = 1'b1;
          q_code = TOK_ACK;
        end
      end
      S_RESTART_WAIT:  if (!tx_busy && !rx_busy) state_d = S_RESTART_PULSE;
      S_RESTART_PULSE: begin
        state_d   = S_BUSY_WAIT;
        restart_d = 1'b1;
      end
      S_BUSY_WAIT:     if (tx_busy && rx_busy) state_d = S_RUN;
      S_RUN: begin
        txd_d = txd_q || tx_done;
        rxd_d = rxd_q || rx_done;
        rxf_d = rxf_q || rx_failed;
        if (txd_q && rxd_q) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (tx_acc) begin
          round_d = round_q + 4'd1;
          txd_d   = 1'b0;
          rxd_d   = 1'b0;
          rxf_d   = 1'b0;
          if (rxf_q) begin
            state_d = S_ERROR;
            fail_d  = 1'b1;
          end else if (round_q + 4'd1 == LAST_RND) begin
            state_d = S_FINISHED;
            done_d  = 1'b1;
          end else begin
            state_d = S_ANNOUNCE;
          end
        end else if (tx_free) begin
          q_tok  = 1'b1;
          q_code = rxf_q ? TOK_FAIL : TOK_PASS;
        end
      end
      S_FINISHED: ;
      S_ERROR: begin
        if (abort_pend_q && tx_free) begin
          q_tok        = 1'b1;
          q_code       = TOK_ABORT;
          abort_pend_d = 1'b0;
        end
      end
      default: state_d = S_ERROR;
    endcase

    // Received ABORT beats alignment loss, which beats the watchdog.
    if (live_st && rx_abort) begin
      err_go = 1'b1;
    end else if (link_st && !rx_aligned) begin
      err_go       = 1'b1;
      abort_pend_d = 1'b1;
    end else if (wd_st && wd_q == TIMEOUT_CYCLES) begin
      err_go       = 1'b1;
      abort_pend_d = 1'b1;
      to_d         = 1'b1;
    end

    if (err_go) begin
      state_d   = S_ERROR;
      fail_d    = 1'b1;
      q_tok     = 1'b0;
      restart_d = 1'b0;
      round_d   = round_q;
      done_d    = done_q;
    end

    if (q_tok) begin
      tx_vld_d  = 1'b1;
      tx_code_d = q_code;
    end

    if (state_d == state_q && wd_st) wd_d = wd_q + 20'd1;
    if (state_d == state_q && state_q == S_ANNOUNCE && ann_q != ANN_LAST) ann_d = ann_q + 1'b1;
    if (state_d != S_ANNOUNCE || state_q != S_ANNOUNCE) start_d = 1'b0;
  end

  assign state                 = state_q;
  assign hs_tx_valid           = tx_vld_q;
  assign hs_tx_code            = tx_code_q;
  assign lbus_tx_rx_restart_in = restart_q;
  assign round_cnt             = round_q;
  assign done                  = done_q;
  assign fail                  = fail_q;
  assign timed_out             = to_q;

endmodule

// File: tb/tb_interlaken_rpt_sequencer.sv
// Bench for interlaken_rpt_sequencer: directed scenarios driven as the remote driver would,
// with a token scoreboard, restart-pulse accounting and link-protocol checks on every cycle.
module tb_interlaken_rpt_sequencer;

  localparam int unsigned NR  = 2;
  localparam int unsigned AP  = 256;
  localparam logic [19:0] TMO = 20'd1000;

  localparam logic [3:0] K_READY = 4'h1, K_ACK = 4'h2, K_START = 4'h3;
  localparam logic [3:0] K_PASS  = 4'h5, K_FAIL = 4'h6, K_ABORT = 4'hF;

  logic       init_clk = 1'b0;
  logic       sys_reset;
  logic       rx_gt_locked, rx_aligned, tx_done, tx_busy, rx_done, rx_busy, rx_failed;
  logic       hs_rx_valid;
  logic [3:0] hs_rx_code;
  logic       hs_tx_valid;
  logic [3:0] hs_tx_code;
  logic       hs_tx_ready;
  logic       lbus_tx_rx_restart_in;
  logic [3:0] round_cnt, state;
  logic       done, fail, timed_out;

  interlaken_rpt_sequencer #(
    .NUM_ROUNDS(NR), .ANNOUNCE_PERIOD(AP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .init_clk(init_clk), .sys_reset(sys_reset),
    .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned),
    .tx_done(tx_done), .tx_busy(tx_busy), .rx_done(rx_done), .rx_busy(rx_busy), .rx_failed(rx_failed),
    .hs_rx_valid(hs_rx_valid), .hs_rx_code(hs_rx_code),
    .hs_tx_valid(hs_tx_valid), .hs_tx_code(hs_tx_code), .hs_tx_ready(hs_tx_ready),
    .lbus_tx_rx_restart_in(lbus_tx_rx_restart_in),
    .round_cnt(round_cnt), .state(state), .done(done), .fail(fail), .timed_out(timed_out)
  );

  always #5 init_clk = ~init_clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge init_clk) cyc <= cyc + 1;

  // Model state: tokens the driver must see (READY excluded), rounds expected so far.
  logic [3:0] exp_q[$];
  int         m_rounds;
  int         readys, restarts;
  logic       pv, pr, prst;
  logic [3:0] pcode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge init_clk);
    #1;
  endtask

  // Link-side observer: token order, hold-under-backpressure and restart pulse shape.
  always @(negedge init_clk) begin
    if (sys_reset) begin
      exp_q.delete();
      readys = 0; restarts = 0;
      pv = 1'b0; pr = 1'b0; prst = 1'b0; pcode = 4'h0;
    end else begin
      if (pv && !pr) begin
        chk("tx_hold_valid", hs_tx_valid, 1);
        chk("tx_hold_code", hs_tx_code, pcode);
      end
      if (lbus_tx_rx_restart_in) begin
        restarts++;
        chk("restart_one_cycle", prst, 0);
        chk("restart_in_busy_wait", state, 6);
      end
      if (hs_tx_valid && hs_tx_ready) begin
        if (hs_tx_code == K_READY) begin
          readys++;
          chk("ready_only_in_announce", state, 2);
        end else if (exp_q.size() == 0) begin
          chk("token_unexpected", hs_tx_code, 0);
        end else begin
          chk("token_order", hs_tx_code, exp_q.pop_front());
        end
      end
      if (done) chk("done_means_finished", state, 9);
      pv = hs_tx_valid; pr = hs_tx_ready; pcode = hs_tx_code; prst = lbus_tx_rx_restart_in;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_tx_valid"}, hs_tx_valid, 0);
    chk({tag, "_tx_code"}, hs_tx_code, 0);
    chk({tag, "_restart"}, lbus_tx_rx_restart_in, 0);
    chk({tag, "_round_cnt"}, round_cnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    rx_gt_locked = 0; rx_aligned = 0; tx_done = 0; tx_busy = 0;
    rx_done = 0; rx_busy = 0; rx_failed = 0;
    hs_rx_valid = 0; hs_rx_code = 4'h0; hs_tx_ready = 1'b1;
    m_rounds = 0;
    repeat (3) step();
    check_reset_vals("rst");
    sys_reset = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, input string nm);
    int n;
    n = 0;
    while (state !== s && n < max) begin
      step();
      n++;
    end
    chk(nm, state, s);
  endtask

  task automatic wait_ready(input int n, input string nm);
    int k;
    k = 0;
    while (readys < n && k < 300) begin
      step();
      k++;
    end
    chk(nm, readys, n);
  endtask

  task automatic send_tok(input logic [3:0] c);
    hs_rx_valid = 1'b1;
    hs_rx_code  = c;
    step();
    hs_rx_valid = 1'b0;
    hs_rx_code  = 4'h0;
  endtask

  task automatic bring_up(input bit check_timing);
    rx_gt_locked = 1'b1;
    wait_state(1, 10, "to_rx_align_wait");
    rx_aligned = 1'b1;
    if (check_timing) begin
      step();
      chk("announce_entry", state, 2);
      chk("ready_not_on_entry", hs_tx_valid, 0);
      step();
      chk("first_ready_valid", hs_tx_valid, 1);
      chk("first_ready_code", hs_tx_code, K_READY);
    end else begin
      wait_state(2, 10, "to_announce");
    end
  endtask

  // From BUSY_WAIT to the report exit. mode 0: tx then rx done; 1: same cycle;
  // 2: rx_done 100 cycles before tx_done; 3: rx_failed then both done.
  task automatic round_tail(input int mode);
    logic [3:0] nxt;
    tx_busy = 1'b1; rx_busy = 1'b1;
    wait_state(7, 5, "to_run");
    exp_q.push_back((mode == 3) ? K_FAIL : K_PASS);
    m_rounds++;
    nxt = (mode == 3) ? 4'd10 : ((m_rounds == NR) ? 4'd9 : 4'd2);
    case (mode)
      0: begin
        tx_done = 1; step(); tx_done = 0; tx_busy = 0;
        repeat (5) step();
        rx_done = 1; step(); rx_done = 0; rx_busy = 0;
      end
      1: begin
        tx_done = 1; rx_done = 1; step();
        tx_done = 0; rx_done = 0; tx_busy = 0; rx_busy = 0;
      end
      2: begin
        rx_done = 1; step(); rx_done = 0; rx_busy = 0;
        repeat (99) step();
        chk("run_holds_with_one_done", state, 7);
        tx_done = 1; step(); tx_done = 0; tx_busy = 0;
      end
      default: begin
        rx_failed = 1; step(); rx_failed = 0;
        repeat (3) step();
        tx_done = 1; rx_done = 1; step();
        tx_done = 0; rx_done = 0; tx_busy = 0; rx_busy = 0;
      end
    endcase
    wait_state(nxt, 12, "report_exit_state");
    chk("round_cnt_after_report", round_cnt, m_rounds);
  endtask

  task automatic run_round(input int mode);
    exp_q.push_back(K_ACK);
    send_tok(K_START);
    wait_state(6, 20, "to_busy_wait");
    round_tail(mode);
  endtask

  int c0, c1, n;

  initial begin
    // Nominal: two rounds, periodic READY, same-cycle done in round 2.
    do_reset();
    bring_up(1);
    repeat (298) step();
    chk("periodic_ready_count", readys, 2);
    run_round(0);
    wait_ready(3, "ready_after_round1");
    run_round(1);
    chk("nom_state", state, 9);
    chk("nom_done", done, 1);
    chk("nom_fail", fail, 0);
    chk("nom_round_cnt", round_cnt, 2);
    chk("nom_timed_out", timed_out, 0);
    step();
    chk("nom_restarts", restarts, 2);
    chk("nom_tokens_left", exp_q.size(), 0);

    // Backpressure on ACK, then rx_done well before tx_done.
    do_reset();
    bring_up(0);
    wait_ready(1, "bp_ready");
    exp_q.push_back(K_ACK);
    hs_tx_ready = 1'b0;
    send_tok(K_START);
    wait_state(3, 10, "bp_to_send_ack");
    repeat (50) step();
    chk("bp_state", state, 3);
    chk("bp_valid", hs_tx_valid, 1);
    chk("bp_code", hs_tx_code, K_ACK);
    chk("bp_no_restart", restarts, 0);
    hs_tx_ready = 1'b1;
    wait_state(6, 10, "bp_to_busy_wait");
    chk("bp_restart_pin", lbus_tx_rx_restart_in, 1);
    round_tail(2);
    wait_ready(2, "bp_ready2");
    run_round(0);
    step();
    chk("bp_restarts", restarts, 2);
    chk("bp_done", done, 1);
    chk("bp_tokens_left", exp_q.size(), 0);

    // Failed round: DONE_FAIL, ERROR, no ABORT.
    do_reset();
    bring_up(0);
    wait_ready(1, "rf_ready");
    run_round(3);
    chk("rf_fail", fail, 1);
    chk("rf_round_cnt", round_cnt, 1);
    chk("rf_timed_out", timed_out, 0);
    repeat (10) step();
    chk("rf_quiet", hs_tx_valid, 0);
    chk("rf_tokens_left", exp_q.size(), 0);

    // Watchdog in BUSY_WAIT with tx_busy held low.
    do_reset();
    bring_up(0);
    wait_ready(1, "wd_ready");
    exp_q.push_back(K_ACK);
    send_tok(K_START);
    wait_state(6, 20, "wd_to_busy_wait");
    c0 = cyc;
    rx_busy = 1'b1;
    exp_q.push_back(K_ABORT);
    n = 0;
    while (state !== 4'd10 && n < 1100) begin
      step();
      n++;
    end
    c1 = cyc;
    chk("wd_state", state, 10);
    chk("wd_latency", c1 - c0, 1001);
    chk("wd_timed_out", timed_out, 1);
    chk("wd_fail", fail, 1);
    repeat (20) step();
    chk("wd_abort_once", exp_q.size(), 0);
    chk("wd_quiet", hs_tx_valid, 0);

    // Received ABORT in ANNOUNCE.
    do_reset();
    bring_up(0);
    wait_ready(1, "ab_ready");
    send_tok(K_ABORT);
    chk("ab_state", state, 10);
    chk("ab_fail", fail, 1);
    chk("ab_timed_out", timed_out, 0);
    repeat (10) step();
    chk("ab_quiet", hs_tx_valid, 0);

    // Alignment loss in ANNOUNCE sends ABORT.
    do_reset();
    bring_up(0);
    wait_ready(1, "al_ready");
    exp_q.push_back(K_ABORT);
    rx_aligned = 1'b0;
    step();
    chk("al_state", state, 10);
    repeat (10) step();
    chk("al_abort_sent", exp_q.size(), 0);

    // Reset in the middle of RUN.
    do_reset();
    bring_up(0);
    wait_ready(1, "mr_ready");
    exp_q.push_back(K_ACK);
    send_tok(K_START);
    wait_state(6, 20, "mr_to_busy_wait");
    tx_busy = 1'b1; rx_busy = 1'b1;
    wait_state(7, 5, "mr_to_run");
    sys_reset = 1'b1;
    step();
    check_reset_vals("midrun");
    sys_reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/interlaken_rpt_sequencer.md
# interlaken_rpt_sequencer

Repeater-side test sequencer for the two-FPGA Interlaken latency bench; it is the responder to the driver-side initiator sequencer. It waits for GT lock and RX alignment and announces readiness to the driver with handshake tokens. On each driver START it restarts the local LBUS TX/RX generators, tracks one packet round to completion, and reports pass/fail back. It sits beside the repeater-configured `interlaken_0_exdes` instance and drives that instance's `lbus_tx_rx_restart_in`.

## Interface
- `NUM_ROUNDS`, 2: packet rounds before FINISHED (1..15).
- `ANNOUNCE_PERIOD`, 1024: cycles between READY tokens in ANNOUNCE (≥ 2).
- `TIMEOUT_CYCLES`, 20'hFFFFF: per-state watchdog limit; 20-bit counter.

Ports:
- `init_clk` in 1: sole clock.
- `sys_reset` in 1: synchronous, active-high reset.
- `rx_gt_locked`, `rx_aligned`, `tx_done`, `tx_busy`, `rx_done`, `rx_busy`, `rx_failed` in 1 each: exdes status levels.
- `hs_rx_valid` in 1: one-cycle strobe, handshake token received from driver.
- `hs_rx_code` in 4: received token code.
- `hs_tx_valid` out 1: token offered to link.
- `hs_tx_code` out 4: offered token code.
- `hs_tx_ready` in 1: link accepts token when high together with `hs_tx_valid`.
- `lbus_tx_rx_restart_in` out 1: one-cycle restart pulse to exdes.
- `round_cnt` out 4: completed rounds.
- `state` out 4: current state encoding.
- `done` out 1: FINISHED reached with all rounds passing.
- `fail` out 1: any round failed or ERROR entered; sticky.
- `timed_out` out 1: watchdog fired; sticky.

## Operation
- Token codes: READY 4'h1, START 4'h3 (rx), ACK 4'h2, DONE_PASS 4'h5, DONE_FAIL 4'h6, ABORT 4'hF (tx and rx). Other received codes are ignored.
- States/encoding: GT_LOCK_WAIT 0, RX_ALIGN_WAIT 1, ANNOUNCE 2, SEND_ACK 3, RESTART_WAIT 4, RESTART_PULSE 5, BUSY_WAIT 6, RUN 7, REPORT 8, FINISHED 9, ERROR 10.
- GT_LOCK_WAIT → RX_ALIGN_WAIT when `rx_gt_locked`. RX_ALIGN_WAIT → ANNOUNCE when `rx_aligned`.
- ANNOUNCE: queue READY on entry, then every `ANNOUNCE_PERIOD` cycles. A due READY is skipped if a token is still pending. A received START is latched; → SEND_ACK once no token is pending.
- SEND_ACK: offer ACK; on acceptance → RESTART_WAIT.
- RESTART_WAIT → RESTART_PULSE when `!tx_busy && !rx_busy`. RESTART_PULSE asserts restart for exactly one cycle, then → BUSY_WAIT.
- BUSY_WAIT → RUN when `tx_busy && rx_busy`.
- RUN: latch `tx_done` and `rx_done` independently, in either order or the same cycle. Latch `rx_failed`. When both done flags are set → REPORT.
- REPORT: offer DONE_FAIL if `rx_failed` was latched, else DONE_PASS. On acceptance, `round_cnt`+1 and clear the latches.
  - After a fail → ERROR.
  - Else, if `round_cnt`+1 == `NUM_ROUNDS` → FINISHED.
  - Else → ANNOUNCE.
- FINISHED: terminal; `done`=1.
- ERROR entry causes: watchdog expiry, `rx_aligned` deasserting in any state from ANNOUNCE through REPORT, received ABORT in any non-terminal state, or a failed REPORT.
  - ERROR offers ABORT once, unless the cause was a received ABORT or a failed REPORT.
  - ERROR is terminal until reset; `fail`=1.
- Precedence within one cycle: received ABORT > alignment loss > watchdog > normal transition.
- Token channel: one token pending at most. `hs_tx_code` holds stable while `hs_tx_valid && !hs_tx_ready`. `hs_tx_valid` drops the cycle after acceptance unless a new token is queued.

## Timing
- All outputs are registered.
- Reset values: `state`=0, `hs_tx_valid`=0, `hs_tx_code`=0, `lbus_tx_rx_restart_in`=0, `round_cnt`=0, `done`=0, `fail`=0, `timed_out`=0. Reset mid-operation aborts silently; no ABORT is sent.
- State changes on the first clock edge at which the condition is sampled true (1-cycle latency).
- Restart pulse: high exactly one cycle, the cycle after RESTART_PULSE entry. Never re-asserted until the next round.
- Watchdog: clears on every state change. Counts in RX_ALIGN_WAIT through REPORT. ERROR is entered on the cycle after the count reaches `TIMEOUT_CYCLES`; `timed_out` is set the same cycle.
- First READY: `hs_tx_valid` high on the cycle after ANNOUNCE entry.

## Test plan
- Nominal 2 rounds, ready tied high: lock, align, START, generator busy/done pulses each round → tokens READY, ACK, DONE_PASS per round; exactly 2 one-cycle restart pulses; `round_cnt`=2, `state`=9, `done`=1, `fail`=0.
- Backpressure: `hs_tx_ready` low for 50 cycles during ACK → code stays 4'h2, valid stays high; restart pulse occurs only after acceptance.
- `rx_failed` pulsed in RUN of round 1 → DONE_FAIL (4'h6) sent, `state`=10, `fail`=1, no ABORT token, `round_cnt`=1.
- Same-cycle `tx_done`/`rx_done`, and `rx_done` 100 cycles before `tx_done` → single REPORT in each case, DONE_PASS.
- Watchdog with `TIMEOUT_CYCLES`=1000: hold `tx_busy` low in BUSY_WAIT → ERROR exactly 1001 cycles after entry, `timed_out`=1, ABORT offered once.
- Received ABORT during ANNOUNCE → ERROR next cycle, no ABORT sent. `sys_reset` mid-RUN → all outputs at reset values the next cycle.
